// File: rtl/exe_pkg.sv
// Shared constants and helpers for the execute stage: ALU opcodes, shift types,
// NZCV bit positions and the multiplier state encoding.
package exe_pkg;

    localparam int DW      = 32;
    localparam int MUL_CYC = 32;

    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMD_MUL = 4'b1010;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/val2_gen.sv
// Operand-2 generator: memory offset, rotated 8-bit immediate, or shifted
// register operand.
module val2_gen
    import exe_pkg::*;
(
    input  logic          mem_en_i,
    input  logic          imm_i,
    input  logic [11:0]   shift_operand_i,
    input  logic [DW-1:0] val_rm_i,
    output logic [DW-1:0] val2_o
);

    logic [4:0] amt;

    always_comb begin
        amt    = shift_operand_i[11:7];
        val2_o = val_rm_i;
        if (mem_en_i) begin
            val2_o = {20'b0, shift_operand_i};
        end else if (imm_i) begin
            val2_o = ror32({24'b0, shift_operand_i[7:0]}, {shift_operand_i[11:8], 1'b0});
        end else begin
            case (shift_operand_i[6:5])
                SHIFT_LSL: val2_o = val_rm_i << amt;
                SHIFT_LSR: val2_o = val_rm_i >> amt;
                SHIFT_ASR: val2_o = $signed(val_rm_i) >>> amt;
                default:   val2_o = ror32(val_rm_i, amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target and, when EXE_MUL_EN
// is defined, an iterative shift-add multiplier that stalls the front-end.
//   state    | meaning
//   MUL_IDLE | no multiply in flight; a MUL opcode raises mul_busy and loads operands
//   MUL_RUN  | one shift-add step per cycle, counting down MUL_CYC-1 .. 0
//   MUL_DONE | product presented on alu_result, flags may be written, front-end released
module exe_stage
    import exe_pkg::*;
#(
    parameter int DW      = exe_pkg::DW,
    parameter int MUL_CYC = exe_pkg::MUL_CYC
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en_i,
    input  logic          mem_r_en_i,
    input  logic          mem_w_en_i,
    input  logic          b_i,
    input  logic          s_i,
    input  logic [3:0]    exe_cmd_i,
    input  logic [DW-1:0] val_rn_i,
    input  logic [DW-1:0] val_rm_i,
    input  logic          imm_i,
    input  logic [11:0]   shift_operand_i,
    input  logic [23:0]   signed_imm_24_i,
    input  logic [DW-1:0] pc_i,
    input  logic [3:0]    sr_i,
    input  logic [3:0]    dest_i,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] val_rm_o,
    output logic [3:0]    dest_o,
    output logic          wb_en_o,
    output logic          mem_r_en_o,
    output logic          mem_w_en_o,
    output logic [DW-1:0] br_addr,
    output logic          branch_taken,
    output logic [3:0]    status,
    output logic          mul_busy
);

    logic [DW-1:0] val2;
    logic [DW-1:0] result;
    logic [DW-1:0] add_b;
    logic          add_cin;
    logic          is_arith;
    logic [DW:0]   sum;
    logic          flag_c;
    logic          flag_v;
    logic [3:0]    status_q, status_d;
    logic          unused_ok;

    val2_gen u_val2_gen (
        .mem_en_i        (mem_r_en_i | mem_w_en_i),
        .imm_i           (imm_i),
        .shift_operand_i (shift_operand_i),
        .val_rm_i        (val_rm_i),
        .val2_o          (val2)
    );

`ifdef EXE_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYC);

    mul_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]  mcand_q, mcand_d;
    logic [DW-1:0]  mplier_q, mplier_d;
    logic [DW-1:0]  prod_q, prod_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            MUL_IDLE: begin
                if (exe_cmd_i == EXE_CMD_MUL) begin
                    state_d  = MUL_RUN;
                    cnt_d    = CNT_W'(MUL_CYC - 1);
                    mcand_d  = val_rn_i;
                    mplier_d = val2;
                    prod_d   = '0;
                end
            end
            MUL_RUN: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) state_d = MUL_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // The MUL opcode stalls in the same cycle it arrives, before RUN is entered.
    always_comb begin
        mul_busy = (state_q == MUL_RUN) ||
                   ((state_q == MUL_IDLE) && (exe_cmd_i == EXE_CMD_MUL));
    end
`else
    assign mul_busy = 1'b0;
`endif

    always_comb begin
        result   = '0;
        add_b    = val2;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        case (exe_cmd_i)
            EXE_CMD_MOV: result = val2;
            EXE_CMD_MVN: result = ~val2;
            EXE_CMD_ADD: is_arith = 1'b1;
            EXE_CMD_ADC: begin is_arith = 1'b1; add_cin = sr_i[FLAG_C]; end
            EXE_CMD_SUB: begin is_arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
            EXE_CMD_SBC: begin is_arith = 1'b1; add_b = ~val2; add_cin = sr_i[FLAG_C]; end
            EXE_CMD_AND: result = val_rn_i & val2;
            EXE_CMD_ORR: result = val_rn_i | val2;
            EXE_CMD_EOR: result = val_rn_i ^ val2;
`ifdef EXE_MUL_EN
            EXE_CMD_MUL: result = prod_q;
`endif
            default:     result = '0;
        endcase
        // Subtraction is rn + ~val2 + cin, so the carry-out is already NOT borrow.
        sum = {1'b0, val_rn_i} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
        if (is_arith) result = sum[DW-1:0];
        flag_c = is_arith ? sum[DW] : sr_i[FLAG_C];
        flag_v = is_arith ? ((val_rn_i[DW-1] == add_b[DW-1]) && (sum[DW-1] != val_rn_i[DW-1]))
                          : sr_i[FLAG_V];
    end

    always_comb begin
        status_d = status_q;
        if (s_i && !mul_busy) begin
            status_d[FLAG_N] = result[DW-1];
            status_d[FLAG_Z] = (result == '0);
            status_d[FLAG_C] = flag_c;
            status_d[FLAG_V] = flag_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) status_q <= '0;
        else     status_q <= status_d;
    end

    assign alu_result   = result;
    assign status       = status_q;
    assign val_rm_o     = val_rm_i;
    assign dest_o       = dest_i;
    assign wb_en_o      = wb_en_i;
    assign mem_r_en_o   = mem_r_en_i;
    assign mem_w_en_o   = mem_w_en_i;
    assign branch_taken = b_i;
    assign br_addr      = pc_i + {{(DW-26){signed_imm_24_i[23]}}, signed_imm_24_i, 2'b00};

    assign unused_ok = ^{sr_i[3:2], MUL_CYC[0]};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, randomized ALU
// traffic against an arithmetic reference model, and multiplier sequences.
module tb_exe_stage;
    import exe_pkg::*;

`ifdef EXE_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_i, mem_r_en_i, mem_w_en_i, b_i, s_i, imm_i;
    logic [3:0]  exe_cmd_i, sr_i, dest_i;
    logic [31:0] val_rn_i, val_rm_i, pc_i;
    logic [11:0] shift_operand_i;
    logic [23:0] signed_imm_24_i;
    logic [31:0] alu_result, val_rm_o, br_addr;
    logic [3:0]  dest_o, status;
    logic        wb_en_o, mem_r_en_o, mem_w_en_o, branch_taken, mul_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i),
        .b_i(b_i), .s_i(s_i), .exe_cmd_i(exe_cmd_i),
        .val_rn_i(val_rn_i), .val_rm_i(val_rm_i), .imm_i(imm_i),
        .shift_operand_i(shift_operand_i), .signed_imm_24_i(signed_imm_24_i),
        .pc_i(pc_i), .sr_i(sr_i), .dest_i(dest_i),
        .alu_result(alu_result), .val_rm_o(val_rm_o), .dest_o(dest_o),
        .wb_en_o(wb_en_o), .mem_r_en_o(mem_r_en_o), .mem_w_en_o(mem_w_en_o),
        .br_addr(br_addr), .branch_taken(branch_taken), .status(status),
        .mul_busy(mul_busy)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic        imm;
        logic        mr;
        logic        s;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] so;
        logic [3:0]  sr;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic imm, input logic mr, input logic mw,
                         input logic s, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic [3:0] sr);
        exe_cmd_i = cmd; imm_i = imm; mem_r_en_i = mr; mem_w_en_i = mw; s_i = s;
        val_rn_i = rn; val_rm_i = rm; shift_operand_i = so; sr_i = sr;
    endtask

    function automatic logic [31:0] rot_right(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int k = 0; k < n; k++) y = {y[0], y[31:1]};
        return y;
    endfunction

    function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                           input logic [11:0] so, input logic [31:0] rm);
        int amt;
        if (mem) return {20'd0, so};
        if (imm) return rot_right({24'd0, so[7:0]}, 2 * int'(so[11:8]));
        amt = int'(so[11:7]);
        case (so[6:5])
            2'd0:    return rm << amt;
            2'd1:    return rm >> amt;
            2'd2:    return rm[31] ? ~((~rm) >> amt) : (rm >> amt);
            default: return rot_right(rm, amt);
        endcase
    endfunction

    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                         input logic [3:0] sr, output logic [31:0] res, output logic [3:0] fl);
        longint sa, sb, ss;
        logic [63:0] ua;
        logic c, v, cin;
        c = sr[1]; v = sr[0];
        sa = $signed(rn); sb = $signed(v2);
        case (cmd)
            4'b0001: res = v2;
            4'b1001: res = ~v2;
            4'b0110: res = rn & v2;
            4'b0111: res = rn | v2;
            4'b1000: res = rn ^ v2;
            4'b0010, 4'b0011: begin
                cin = (cmd == 4'b0011) ? sr[1] : 1'b0;
                ua  = {32'd0, rn} + {32'd0, v2} + {63'd0, cin};
                res = ua[31:0];
                c   = (ua >= 64'h1_0000_0000);
                ss  = sa + sb + (cin ? 64'sd1 : 64'sd0);
                v   = (ss > SMAX) || (ss < SMIN);
            end
            4'b0100, 4'b0101: begin
                cin = (cmd == 4'b0101) ? !sr[1] : 1'b0;
                res = rn - v2 - {31'd0, cin};
                c   = ({32'd0, rn} >= ({32'd0, v2} + {63'd0, cin}));
                ss  = sa - sb - (cin ? 64'sd1 : 64'sd0);
                v   = (ss > SMAX) || (ss < SMIN);
            end
            default: res = 32'd0;
        endcase
        fl = {res[31], res == 32'd0, c, v};
    endtask

    logic [3:0]  exp_st;
    logic [31:0] m_res;
    logic [3:0]  m_fl;
    int          busy_cnt;

    initial begin
        vecs[0]  = '{EXE_CMD_ADD, 1'b1, 1'b0, 1'b1, 32'd5,        32'd0,        12'h007, 4'h0, 32'd12,       4'b0000};
        vecs[1]  = '{EXE_CMD_SUB, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd1,        12'h000, 4'h0, 32'h7FFFFFFF, 4'b0011};
        vecs[2]  = '{EXE_CMD_MOV, 1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        12'h4FF, 4'h0, 32'hFF000000, 4'b0011};
        vecs[3]  = '{EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 32'd0,        32'h80000010, 12'h240, 4'h0, 32'hF8000001, 4'b1000};
        vecs[4]  = '{EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 32'd0,        32'h000000AB, 12'h460, 4'h0, 32'hAB000000, 4'b1000};
        vecs[5]  = '{EXE_CMD_ADC, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        12'h000, 4'h2, 32'd0,        4'b0110};
        vecs[6]  = '{EXE_CMD_MVN, 1'b1, 1'b0, 1'b1, 32'd0,        32'd0,        12'h000, 4'h0, 32'hFFFFFFFF, 4'b1000};
        vecs[7]  = '{EXE_CMD_SBC, 1'b1, 1'b0, 1'b1, 32'd5,        32'd0,        12'h005, 4'h0, 32'hFFFFFFFF, 4'b1000};
        vecs[8]  = '{EXE_CMD_ADD, 1'b1, 1'b1, 1'b0, 32'h1000,     32'd0,        12'hFFF, 4'h0, 32'h00001FFF, 4'b1000};
        vecs[9]  = '{4'b1111,     1'b1, 1'b0, 1'b1, 32'd9,        32'd9,        12'h011, 4'h3, 32'd0,        4'b0111};
        vecs[10] = '{EXE_CMD_ORR, 1'b0, 1'b0, 1'b1, 32'd0,        32'd1,        12'hF80, 4'h0, 32'h80000000, 4'b1000};
        vecs[11] = '{EXE_CMD_EOR, 1'b0, 1'b0, 1'b0, 32'd3,        32'h80000000, 12'hFA0, 4'h0, 32'd2,        4'b1000};

        rst = 1'b1; wb_en_i = 1'b0; b_i = 1'b0; dest_i = 4'd0;
        pc_i = 32'd0; signed_imm_24_i = 24'd0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("reset_status", 32'(status), 32'd0);
        chk("reset_busy", 32'(mul_busy), 32'd0);

        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].cmd, vecs[i].imm, vecs[i].mr, 1'b0, vecs[i].s,
                  vecs[i].rn, vecs[i].rm, vecs[i].so, vecs[i].sr);
            dest_i = 4'(i); wb_en_i = i[0];
            #2;
            chk($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
            chk($sformatf("vec%0d_pass", i), {val_rm_o[27:0], dest_o},
                {vecs[i].rm[27:0], 4'(i)});
            chk($sformatf("vec%0d_ctl", i), {29'd0, wb_en_o, mem_r_en_o, mem_w_en_o},
                {29'd0, i[0], vecs[i].mr, 1'b0});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].exp_st));
        end

        pc_i = 32'h100; signed_imm_24_i = 24'hFFFFFE; b_i = 1'b1;
        #2;
        chk("br_back", br_addr, 32'h000000F8);
        chk("br_taken", 32'(branch_taken), 32'd1);
        pc_i = 32'hFFFFFFFC; signed_imm_24_i = 24'h000001; b_i = 1'b0;
        #2;
        chk("br_wrap", br_addr, 32'h00000000);
        chk("br_not_taken", 32'(branch_taken), 32'd0);
        @(posedge clk); #1;

        exp_st = status;
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  cmd;
            logic        imm, mr, mw, s;
            logic [31:0] rn, rm, v2;
            logic [11:0] so;
            logic [3:0]  sr;
            cmd = 4'($urandom_range(0, 15));
            if (cmd == EXE_CMD_MUL) cmd = EXE_CMD_ADD;
            imm = 1'($urandom); mr = ($urandom_range(0, 7) == 0); mw = ($urandom_range(0, 7) == 0);
            s = 1'($urandom); rn = $urandom; rm = $urandom; so = 12'($urandom); sr = 4'($urandom);
            if (i % 5 == 0) rn = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
            drive(cmd, imm, mr, mw, s, rn, rm, so, sr);
            v2 = m_val2(mr | mw, imm, so, rm);
            m_alu(cmd, rn, v2, sr, m_res, m_fl);
            #2;
            chk($sformatf("rnd%0d_result", i), alu_result, m_res);
            if (s) exp_st = m_fl;
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_status", i), 32'(status), 32'(exp_st));
        end

        drive(EXE_CMD_MOV, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 12'h000, 4'h0);
        @(posedge clk); #1;
        chk("pre_mul_status", 32'(status), 32'b0100);

        drive(EXE_CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b1, 32'd6, 32'd0, 12'h007, 4'b0011);
        #1;
        if (MUL_ON) begin
            busy_cnt = 0;
            for (int k = 0; k < 100 && mul_busy; k++) begin
                busy_cnt++;
                if (k == 5) chk("mul_status_frozen", 32'(status), 32'b0100);
                @(posedge clk); #2;
            end
            chk("mul_busy_cycles", busy_cnt, 32'd33);
            chk("mul_result", alu_result, 32'd42);
            @(posedge clk); #1;
            drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'd0, 4'd0);
            #1;
            chk("mul_status", 32'(status), 32'b0011);
            chk("mul_idle_busy", 32'(mul_busy), 32'd0);

            drive(EXE_CMD_MUL, 1'b1, 1'b0, 1'b0, 1'b1, 32'd6, 32'd0, 12'h007, 4'b0011);
            repeat (11) @(posedge clk);
            #2;
            chk("mul_busy_before_rst", 32'(mul_busy), 32'd1);
            rst = 1'b1;
            drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'd0, 4'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("mul_rst_busy", 32'(mul_busy), 32'd0);
            chk("mul_rst_status", 32'(status), 32'd0);
        end else begin
            chk("mul_off_result", alu_result, 32'd0);
            chk("mul_off_busy", 32'(mul_busy), 32'd0);
            @(posedge clk); #1;
            chk("mul_off_status", 32'(status), 32'b0111);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
